// File: rtl/spmv_vec_reader_if.sv
// Bundles the command, AXI4 read and AXI-Stream output signals of the vector reader.
// Latency: none, this is wiring only.
// Backpressure: carried by the ready/valid pairs inside; the master modport is the reader's view.
interface spmv_vec_reader_if;
    // Command channel
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_addr;
    logic [15:0] cmd_len;
    // AXI4 read address channel
    logic [3:0]  m_axi_arid;
    logic [31:0] m_axi_araddr;
    logic [7:0]  m_axi_arlen;
    logic [2:0]  m_axi_arsize;
    logic [1:0]  m_axi_arburst;
    logic        m_axi_arvalid;
    logic        m_axi_arready;
    // AXI4 read data channel
    logic [3:0]  m_axi_rid;
    logic [31:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;
    logic        m_axi_rlast;
    logic        m_axi_rvalid;
    logic        m_axi_rready;
    // AXI-Stream output
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;

    modport master (
        input  cmd_valid, cmd_addr, cmd_len,
        output cmd_ready,
        output m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
        input  m_axi_arready,
        input  m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
        output m_axi_rready,
        output m_axis_tdata, m_axis_tvalid, m_axis_tlast,
        input  m_axis_tready
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_len,
        input  cmd_ready,
        input  m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
        output m_axi_arready,
        output m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
        input  m_axi_rready,
        input  m_axis_tdata, m_axis_tvalid, m_axis_tlast,
        output m_axis_tready
    );
endinterface

// File: rtl/spmv_vec_reader.sv
// Turns (byte addr, word count) commands into 4 KB-safe INCR read bursts and streams the words out with tlast.
// Latency: cmd -> arvalid 1 cycle, R beat -> tvalid 1 cycle, one idle cycle between bursts of a command.
// Backpressure: single-entry output register; rready drops while that register is full and tready is low.
module spmv_vec_reader #(
    parameter int unsigned MAX_BURST = 16,
    parameter logic [3:0]  AXI_ID    = 4'h0
) (
    input  logic              s_aclk,
    input  logic              s_areset,
    spmv_vec_reader_if.master bus,
    output logic              busy,
    output logic              done,
    output logic              err
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    localparam logic [16:0] LP_MAX = 17'(MAX_BURST);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_addr;
    logic [15:0] r_rem;
    logic [31:0] r_araddr;
    logic [7:0]  r_arlen;
    logic [8:0]  r_cnt;
    logic [31:0] r_tdata;
    logic        r_tvalid;
    logic        r_tlast;
    logic        r_err;
    logic        r_zdone;

    logic        w_cmd_rdy;
    logic        w_arvalid;
    logic        w_rready;
    logic        w_cmd_hs;
    logic        w_ar_hs;
    logic        w_r_hs;
    logic        w_t_hs;
    logic        w_cnt_last;
    logic [31:0] w_src_addr;
    logic [15:0] w_src_rem;
    logic [10:0] w_room;
    logic [16:0] w_b0;
    logic [16:0] w_beats;
    logic [8:0]  w_cur_beats;
    logic        w_unused;

    assign w_cmd_hs    = bus.cmd_valid && w_cmd_rdy;
    assign w_ar_hs     = w_arvalid && bus.m_axi_arready;
    assign w_r_hs      = bus.m_axi_rvalid && w_rready;
    assign w_t_hs      = r_tvalid && bus.m_axis_tready;
    assign w_cnt_last  = (r_cnt == 9'd1);
    assign w_cur_beats = {1'b0, r_arlen} + 9'd1;

    // The next burst starts from the incoming command in IDLE, otherwise from the running address.
    assign w_src_addr = (r_state == IDLE) ? {bus.cmd_addr[31:2], 2'b00} : r_addr;
    assign w_src_rem  = (r_state == IDLE) ? bus.cmd_len : r_rem;
    assign w_room     = 11'd1024 - {1'b0, w_src_addr[11:2]};
    assign w_b0       = ({1'b0, w_src_rem} < LP_MAX) ? {1'b0, w_src_rem} : LP_MAX;
    assign w_beats    = (w_b0 < {6'd0, w_room}) ? w_b0 : {6'd0, w_room};

    // State register.
    always_ff @(posedge s_aclk) begin
        if (s_areset) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next-state and FSM-decoded handshake outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_cmd_rdy   = 1'b0;
        w_arvalid   = 1'b0;
        w_rready    = 1'b0;
        busy        = 1'b1;
        case (r_state)
            IDLE: begin
                busy      = 1'b0;
                w_cmd_rdy = !s_areset;
                if (bus.cmd_valid && !s_areset && (bus.cmd_len != 16'd0))
                    w_state_nxt = ADDR;
            end
            ADDR: begin
                w_arvalid = 1'b1;
                if (bus.m_axi_arready) w_state_nxt = DATA;
            end
            DATA: begin
                w_rready = !r_tvalid || bus.m_axis_tready;
                if (bus.m_axi_rvalid && w_rready && w_cnt_last)
                    w_state_nxt = (r_rem != 16'd0) ? ADDR : IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Command latch, burst bookkeeping, output register and sticky error.
    always_ff @(posedge s_aclk) begin
        if (s_areset) begin
            r_addr   <= '0;
            r_rem    <= '0;
            r_araddr <= '0;
            r_arlen  <= '0;
            r_cnt    <= '0;
            r_tdata  <= '0;
            r_tvalid <= 1'b0;
            r_tlast  <= 1'b0;
            r_err    <= 1'b0;
            r_zdone  <= 1'b0;
        end else begin
            r_zdone <= w_cmd_hs && (bus.cmd_len == 16'd0);
            if (w_cmd_hs) begin
                r_addr <= w_src_addr;
                r_rem  <= bus.cmd_len;
            end
            // Burst size is frozen on entry to ADDR so araddr/arlen stay stable until arready.
            if ((r_state != ADDR) && (w_state_nxt == ADDR)) begin
                r_araddr <= w_src_addr;
                r_arlen  <= 8'(w_beats - 17'd1);
            end
            if (w_ar_hs) begin
                r_addr <= r_addr + {21'd0, w_cur_beats, 2'b00};
                r_rem  <= r_rem - {7'd0, w_cur_beats};
                r_cnt  <= w_cur_beats;
            end
            if (w_r_hs) begin
                r_tdata  <= bus.m_axi_rdata;
                r_tvalid <= 1'b1;
                r_tlast  <= w_cnt_last && (r_rem == 16'd0);
                r_cnt    <= r_cnt - 9'd1;
                if ((bus.m_axi_rresp != 2'b00) || (bus.m_axi_rlast != w_cnt_last))
                    r_err <= 1'b1;
            end else if (w_t_hs) begin
                r_tvalid <= 1'b0;
                r_tlast  <= 1'b0;
            end
        end
    end

    assign bus.cmd_ready     = w_cmd_rdy;
    assign bus.m_axi_arid    = AXI_ID;
    assign bus.m_axi_araddr  = r_araddr;
    assign bus.m_axi_arlen   = r_arlen;
    assign bus.m_axi_arsize  = 3'b010;
    assign bus.m_axi_arburst = 2'b01;
    assign bus.m_axi_arvalid = w_arvalid;
    assign bus.m_axi_rready  = w_rready;
    assign bus.m_axis_tdata  = r_tdata;
    assign bus.m_axis_tvalid = r_tvalid;
    assign bus.m_axis_tlast  = r_tlast;

    assign done = (w_t_hs && r_tlast) || r_zdone;
    assign err  = r_err;

    // rid and the low address bits carry no information for this reader.
    assign w_unused = ^{bus.m_axi_rid, bus.cmd_addr[1:0]};
endmodule

// File: doc/spmv_vec_reader.md
# spmv_vec_reader

AXI4 read master that turns a (byte address, word count) command into one or more INCR bursts against the SpMV kernel's AXI block-RAM slave. It re-emits the returned 32-bit words as an AXI-Stream with `tlast` on the final word. It sits directly upstream of the BRAM read port and feeds vector or index words to the SpMV datapath. One burst is outstanding at a time.

## Interface
- `MAX_BURST`, default 16: maximum beats per burst, range 1..256.
- `AXI_ID`, default 4'h0: constant value driven on `m_axi_arid`.
- `s_aclk` in 1: clock. One clock domain; all signals are synchronous to `s_aclk`.
- `s_areset` in 1: reset, synchronous, active-high.
- `cmd_valid` in 1: command valid.
- `cmd_ready` out 1: command ready.
- `cmd_addr` in 32: start byte address; bits [1:0] are ignored and treated as 0.
- `cmd_len` in 16: word count; 0 is legal.
- `m_axi_arid` out 4: read ID, always `AXI_ID`.
- `m_axi_araddr` out 32: burst start address.
- `m_axi_arlen` out 8: beats minus 1.
- `m_axi_arsize` out 3: constant 3'b010 (4 bytes).
- `m_axi_arburst` out 2: constant 2'b01 (INCR).
- `m_axi_arvalid` / `m_axi_arready` out / in 1: read-address handshake.
- `m_axi_rid` in 4: ignored.
- `m_axi_rdata` in 32: read data.
- `m_axi_rresp` in 2: read response.
- `m_axi_rlast` in 1: last beat of burst.
- `m_axi_rvalid` / `m_axi_rready` in / out 1: read-data handshake.
- `m_axis_tdata` out 32: output word.
- `m_axis_tvalid` / `m_axis_tready` out / in 1: output-stream handshake.
- `m_axis_tlast` out 1: marks the final word of the command.
- `busy` out 1: high whenever the FSM is not in IDLE.
- `done` out 1: one-cycle pulse on the `tlast` stream handshake, or on acceptance of a zero-length command.
- `err` out 1: sticky flag, set by any `rresp != 0`; cleared only by reset.

## Operation
- State machine states: IDLE, ADDR, DATA.
- **IDLE**
  - `cmd_ready = 1`.
  - On `cmd_valid && cmd_ready`: latch `addr = {cmd_addr[31:2], 2'b00}` and `rem = cmd_len`.
  - If `cmd_len == 0`: pulse `done` next cycle and stay in IDLE.
  - Otherwise go to ADDR.
- **Burst size** (computed on entry to ADDR): `beats = min(rem, MAX_BURST, (4096 - addr[11:0]) >> 2)`.
  - A burst never crosses a 4 KB boundary.
  - `arlen = beats - 1`; `araddr = addr`.
- **ADDR**
  - `arvalid = 1`; `araddr` and `arlen` are held stable until `arready`.
  - On the handshake: `addr += beats*4`, `rem -= beats`, load the beat counter with `beats`, go to DATA.
- **DATA**
  - Each accepted R beat loads the output register and decrements the beat counter.
  - `tlast = (beat counter == 1) && (rem == 0)`.
  - On the accepted beat where the counter reaches 0: go to ADDR if `rem != 0`, else go to IDLE.
  - `m_axi_rlast` is not used for sequencing. A mismatch between `rlast` and the counter sets `err`.
- **Output register**: single-entry pipeline stage.
  - `m_axi_rready = (state == DATA) && (!m_axis_tvalid || m_axis_tready)`.
  - No word is lost or duplicated under any `tready` pattern.
- **Back-to-back commands**: a new command may be accepted while the previous command's last word still sits in the output register. Stream order is preserved.
- **`err`**: set by a non-OKAY `rresp` or an `rlast` mismatch. Data is still forwarded and the command completes normally.
- **`rem` width**: 16 bits. `addr` wraps modulo 2^32 without a special case.

## Timing
- **Reset values**: `cmd_ready = 0` during reset, then 1 in IDLE. `m_axi_arvalid = 0`, `m_axi_rready = 0`, `m_axis_tvalid = 0`, `m_axis_tlast = 0`, `busy = 0`, `done = 0`, `err = 0`, state = IDLE. `araddr`, `arlen` and `tdata` reset to 0.
- **Reset mid-operation**: abandons the command and outstanding burst immediately. The bench must quiesce the slave as well.
- **Latency**
  - Command accept → `arvalid`: 1 cycle.
  - AR handshake → `rready` high: next cycle.
  - R beat accepted → `tvalid`: next cycle.
  - Last R beat of a burst → next `arvalid`: 1 cycle, giving one idle cycle between bursts.
- **Throughput**: 1 word/cycle within a burst when `tready = 1`.
- **`done` timing**: asserted in the same cycle as the `tvalid && tready && tlast` handshake (combinational on the handshake) and held for exactly 1 cycle. For zero-length commands it is a registered pulse.
- **Valid rules**: `arvalid` and `tvalid` never drop without their matching handshake.

## Test plan
- **Single short burst**: `cmd_addr = 0x0`, `cmd_len = 5`, `tready = 1` → one AR with `araddr = 0x0`, `arlen = 4`; 5 words out in order; `tlast` on word 5; `done` pulses once.
- **Burst split**: `cmd_addr = 0x100`, `cmd_len = 40`, `MAX_BURST = 16` → ARs (0x100, 15), (0x140, 15), (0x180, 7); 40 words out; single `tlast`.
- **4 KB boundary**: `cmd_addr = 0xFF8`, `cmd_len = 4` → ARs (0xFF8, 1) then (0x1000, 1).
- **Backpressure**: `cmd_len = 32`, random `tready` at 30% duty, continuous `rvalid` → the scoreboard matches all 32 words exactly; `rready` is 0 whenever `tvalid && !tready`.
- **Error response**: `rresp = 2'b10` on beat 2 of a 4-word command → `err = 1` and stays 1; all 4 words delivered; `done` pulses.
- **Zero length and reset mid-burst**
  - `cmd_len = 0` → no AR, `done` pulses, `busy` stays 0.
  - `s_areset` asserted mid-DATA → all outputs return to reset values.
  - A following `cmd_len = 3` completes correctly.
